// File: rtl/acc_pkg.sv
// Shared widths and state encoding for the frame accumulator.
package acc_pkg;
  localparam int ACC_W  = 4;
  localparam int BEAT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } acc_state_t;
endpackage

// File: rtl/accumulator_4bit_if.sv
// Operand-in / frame-result-out handshake bundle for accumulator_4bit.
interface accumulator_4bit_if;
  import acc_pkg::*;

  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] A;
  logic             Cin;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] Sum;
  logic             Ovf;

  // master is the producer/consumer side, slave is the accumulator itself
  modport master (
    output clear, in_valid, A, Cin, out_ready,
    input  in_ready, out_valid, Sum, Ovf
  );

  modport slave (
    input  clear, in_valid, A, Cin, out_ready,
    output in_ready, out_valid, Sum, Ovf
  );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder, the cell the ripple-carry adder is built from.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripplecarryadder_4bit.sv
// Four full adders chained LSB to MSB; Cout is the carry out of bit 3.
module ripplecarryadder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [4:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    full_adder u_fa (
      .a   (A[i]),
      .b   (B[i]),
      .cin (carry[i]),
      .s   (Sum[i]),
      .cout(carry[i+1])
    );
  end

  assign Cout = carry[4];
endmodule

// File: rtl/accumulator_4bit.sv
// Folds COUNT operands into a 4-bit running sum and offers the frame total.
// Optional ACC_SATURATE_EN: pin the total at 15 once any carry-out occurs.
module accumulator_4bit
  import acc_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  accumulator_4bit_if.slave  bus
);
  acc_state_t        state;
  logic [ACC_W-1:0]  acc;
  logic              ovf;
  logic [BEAT_W-1:0] beat;

  logic [ACC_W-1:0]  add_sum;
  logic              add_cout;
  logic [ACC_W-1:0]  acc_next;
  logic [BEAT_W-1:0] beat_next;
  logic              last_beat;

  ripplecarryadder_4bit u_adder (
    .A   (acc),
    .B   (bus.A),
    .Cin (bus.Cin),
    .Sum (add_sum),
    .Cout(add_cout)
  );

`ifdef ACC_SATURATE_EN
  assign acc_next = (add_cout || ovf) ? {ACC_W{1'b1}} : add_sum;
`else
  assign acc_next = add_sum;
`endif

  assign beat_next = beat + BEAT_W'(1);
  assign last_beat = (beat_next == BEAT_W'(COUNT));

  // Handshake flags are pure state decodes, so they are glitch-free registers in effect.
  assign bus.in_ready  = (state != EMIT);
  assign bus.out_valid = (state == EMIT);
  // acc and ovf are frozen in EMIT, so they serve directly as the registered result.
  assign bus.Sum       = acc;
  assign bus.Ovf       = ovf;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      beat  <= '0;
    end else if (bus.clear) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      beat  <= '0;
    end else begin
      unique case (state)
        IDLE, ACCUM: begin
          if (bus.in_valid) begin
            acc   <= acc_next;
            ovf   <= ovf | add_cout;
            beat  <= beat_next;
            state <= last_beat ? EMIT : ACCUM;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            beat  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accumulator_4bit.sv
// Directed frames with a queue-based scoreboard checked by an independent monitor.
module tb_accumulator_4bit;
  logic clk;
  logic rst;

  accumulator_4bit_if bus ();

  accumulator_4bit #(.COUNT(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] sum;
    logic       ovf;
  } result_t;

  result_t expq[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a result leaves the DUT whenever out_valid && out_ready at an edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (expq.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          result_t e;
          e = expq.pop_front();
          check("frame_sum", 32'(bus.Sum), 32'(e.sum));
          check("frame_ovf", 32'(bus.Ovf), 32'(e.ovf));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] a, input logic c);
    int n;
    bus.in_valid = 1'b1;
    bus.A        = a;
    bus.Cin      = c;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    tick();
  endtask

  task automatic push(input logic [3:0] s, input logic o);
    result_t r;
    r.sum = s;
    r.ovf = o;
    expq.push_back(r);
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.A        = 4'd0;
    bus.Cin      = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.Sum),       32'd0);
    check("rst_ovf",       32'(bus.Ovf),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Basic frame: 3+5+1+2 = 11, back-to-back
    push(4'd11, 1'b0);
    send(4'd3, 1'b0);
    send(4'd5, 1'b0);
    send(4'd1, 1'b0);
    check("basic_no_early_valid", 32'(bus.out_valid), 32'd0);
    send(4'd2, 1'b0);
    idle_inputs();
    check("basic_latency_valid", 32'(bus.out_valid), 32'd1);
    check("basic_emit_in_ready", 32'(bus.in_ready),  32'd0);
    tick();
    check("basic_back_to_idle", 32'(bus.in_ready), 32'd1);

    // Overflow: 9+6=15, +7 carries out (6), +8 = 14
`ifdef ACC_SATURATE_EN
    push(4'd15, 1'b1);
`else
    push(4'd14, 1'b1);
`endif
    send(4'd9, 1'b0);
    send(4'd6, 1'b0);
    send(4'd7, 1'b0);
    send(4'd8, 1'b0);
    idle_inputs();
    tick();

    // Carry-in with gaps: 10+1=11, +3=14, +0, +1 = 15
    push(4'd15, 1'b0);
    send(4'd10, 1'b1);
    idle_inputs();
    repeat (2) tick();
    send(4'd3, 1'b0);
    idle_inputs();
    tick();
    send(4'd0, 1'b0);
    idle_inputs();
    repeat (3) tick();
    send(4'd1, 1'b0);
    idle_inputs();
    tick();

    // Backpressure: 2+2+2+2 = 8 held in EMIT for 5 cycles
    push(4'd8, 1'b0);
    bus.out_ready = 1'b0;
    send(4'd2, 1'b0);
    send(4'd2, 1'b0);
    send(4'd2, 1'b0);
    send(4'd2, 1'b1 ^ 1'b1);
    bus.in_valid = 1'b1;
    bus.A        = 4'd5;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
      check("bp_sum",       32'(bus.Sum),       32'd8);
      check("bp_ovf",       32'(bus.Ovf),       32'd0);
      tick();
    end
    idle_inputs();
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Next frame after release must start from zero: 4+4+4+3 = 15
    push(4'd15, 1'b0);
    send(4'd4, 1'b0);
    send(4'd4, 1'b0);
    send(4'd4, 1'b0);
    send(4'd3, 1'b0);
    idle_inputs();
    tick();

    // Clear mid-frame drops the operand presented alongside it
    send(4'd7, 1'b0);
    send(4'd7, 1'b0);
    bus.in_valid = 1'b1;
    bus.A        = 4'd4;
    bus.clear    = 1'b1;
    tick();
    bus.clear = 1'b0;
    idle_inputs();
    check("clear_in_ready",  32'(bus.in_ready),  32'd1);
    check("clear_out_valid", 32'(bus.out_valid), 32'd0);
    push(4'd4, 1'b0);
    for (int i = 0; i < 4; i++) send(4'd1, 1'b0);
    idle_inputs();
    tick();

    // Asynchronous reset between edges after three operands
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    send(4'd5, 1'b0);
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_in_ready",  32'(bus.in_ready),  32'd1);
    check("arst_sum",       32'(bus.Sum),       32'd0);
    check("arst_ovf",       32'(bus.Ovf),       32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    push(4'd10, 1'b0);
    send(4'd4, 1'b0);
    send(4'd3, 1'b0);
    send(4'd2, 1'b0);
    send(4'd1, 1'b0);
    idle_inputs();

    for (int i = 0; i < 20 && expq.size() > 0; i++) tick();
    check("scoreboard_drained", 32'(expq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/accumulator_4bit.md
# accumulator_4bit

Frame accumulator sitting directly downstream of `ripplecarryadder_4bit`. It accepts a stream of 4-bit operands over a valid/ready handshake and folds each into a running 4-bit sum through one `ripplecarryadder_4bit` instance. After `COUNT` operands it presents the frame total plus a sticky overflow flag on an output handshake. This is the first registered arithmetic stage built on the adder.

## Interface
- `COUNT`, default 4: operands per frame; legal range 1..15.
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `clear`  input  1  synchronous frame abort.
- `in_valid`  input  1  operand present.
- `in_ready`  output  1  block can accept an operand.
- `A`  input  4  operand.
- `Cin`  input  1  per-operand carry-in, added with `A`.
- `out_valid`  output  1  frame result present.
- `out_ready`  input  1  consumer takes the result.
- `Sum`  output  4  frame total.
- `Ovf`  output  1  a carry-out occurred in this frame.

## Operation
- **Adder wiring:** adder inputs are `A=acc`, `B=A` (operand), `Cin=Cin`.
- **Accept:** an operand is accepted when `in_valid && in_ready` at a rising edge. On accept:
  - `acc <= adder Sum`
  - `ovf <= ovf | adder Cout`
  - `beat <= beat + 1`
- **State machine:**
  - **IDLE:** `beat==0`, `acc==0`. `in_ready=1`. First accept goes to ACCUM, or straight to EMIT when `COUNT==1`.
  - **ACCUM:** `in_ready=1`. The accept that makes `beat==COUNT` goes to EMIT. Otherwise stay in ACCUM.
  - **EMIT:** `in_ready=0`, `out_valid=1`, `Sum=acc`, `Ovf=ovf`, all held stable. When `out_ready=1` at an edge, go to IDLE with `acc=0`, `ovf=0`, `beat=0`.
- **Outputs:**
  - `in_ready` and `out_valid` are decoded from state only.
  - `Sum` and `Ovf` are registered and valid only while `out_valid=1`.
- **Width rule:** 4-bit wrap-around arithmetic. Carry beyond bit 3 is not stored; it only sets `ovf`.
- **`clear`:** highest synchronous priority. At the edge: go to IDLE, `acc=0`, `ovf=0`, `beat=0`. Any operand or output handshake in that cycle is discarded.
- **Reset, any time including mid-frame:** state IDLE, `acc=0`, `ovf=0`, `beat=0`. Output reset values: `in_ready=1`, `out_valid=0`, `Sum=0`, `Ovf=0`.

## Timing
- Each operand is added in the cycle it is accepted; the result is registered at that edge.
- Throughput: one operand per cycle while `in_ready=1`.
- Latency: `out_valid` rises in the cycle after the `COUNT`-th accept.
- No operand is accepted during EMIT, including the cycle of the output handshake. `in_ready` returns to 1 in the cycle after `out_valid && out_ready`.
- Minimum frame period: `COUNT+1` cycles.
- `out_valid` never drops without `out_ready` or `clear`/`rst`.

## Configuration
- `ACC_SATURATE_EN` defined: on any accept where adder `Cout=1`, or where `ovf` is already 1, `acc <= 4'd15`. The frame total pins at 15 and `Ovf=1`.
- `ACC_SATURATE_EN` undefined: modulo-16 wrap, with `Ovf` set sticky.

## Structure
- **Shared package `acc_pkg`:**
  - `ACC_W=4`
  - `BEAT_W=4`
  - state typedef `acc_state_t {IDLE, ACCUM, EMIT}`
- **Sub-module:** one, the existing `ripplecarryadder_4bit` (built from `full_adder`), instantiated once. No other hierarchy.

## Test plan
- **Basic frame:** `COUNT=4`, operands 3,5,1,2 with `Cin=0`, back-to-back -> `out_valid` one cycle after the 4th accept, `Sum=11`, `Ovf=0`.
- **Overflow:** operands 9,6,7,8 -> without the macro `Sum=14`, `Ovf=1`. With `ACC_SATURATE_EN`: `Sum=15`, `Ovf=1`.
- **Carry-in and gaps:** operands 10 (`Cin=1`), 3, 0, 1 with `in_valid` gaps between them -> `Sum=15`, `Ovf=0`. Gap cycles leave `acc` unchanged.
- **Backpressure:** hold `out_ready=0` for 5 cycles in EMIT -> `out_valid`, `Sum`, `Ovf` stable and `in_ready=0` throughout. On release, `in_ready=1` next cycle and the next frame starts from 0.
- **Clear mid-frame:** two operands 7,7, then `clear` together with `in_valid` (`A=4`) -> IDLE; that operand is dropped. The following frame 1,1,1,1 gives `Sum=4`, `Ovf=0`.
- **Reset mid-frame:** assert `rst` asynchronously between edges after three operands -> `out_valid=0`, `Sum=0`, `Ovf=0`, `in_ready=1` immediately. A fresh frame after release gives the correct total.
